tremolo_mc: RTL and testbench

Multi-channel, parametrised tremolo for the pedal audio path, clocked once per stereo frame by `Lrck`. It amplitude-modulates `CHANNELS` signed samples with a selectable-shape LFO: square, triangle or ramp. Per-channel phase spread provides auto-pan, and a `Sync` input retriggers the LFO. Disabled operation is a delay-matched bypass, so toggling `Enable` introduces no timing slip.

---
 rtl/tremolo_pkg.sv | 34 +++
 rtl/tremolo_lfo_shape.sv | 28 ++
 rtl/tremolo_mc.sv | 131 +++++++++++++
 tb/tb_tremolo_mc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tremolo_pkg.sv
// Shared types, constants and gain arithmetic for the tremolo_mc slice.
package tremolo_pkg;

  // The LFO level path is 8 bits wide regardless of the control word width.
  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;
  localparam logic [8:0] GAIN_UNITY = 9'd256;

  // Mode input encodings.
  localparam logic [1:0] MODE_ENC_SQUARE     = 2'b00;
  localparam logic [1:0] MODE_ENC_TRIANGLE   = 2'b01;
  localparam logic [1:0] MODE_ENC_RAMP       = 2'b10;
  localparam logic [1:0] MODE_ENC_SQUARE_ALT = 2'b11;

  typedef enum logic [1:0] {
    MODE_SQUARE     = MODE_ENC_SQUARE,
    MODE_TRIANGLE   = MODE_ENC_TRIANGLE,
    MODE_RAMP       = MODE_ENC_RAMP,
    MODE_SQUARE_ALT = MODE_ENC_SQUARE_ALT
  } mode_e;

  // Depth-scaled attenuation of an LFO level, returned as a 9-bit gain.
  // Full attenuation maps to a hard zero so Depth=255 really mutes; zero
  // attenuation maps to 256 so the multiplier passes the sample unchanged.
  function automatic logic [8:0] level_to_gain(input logic [LEVEL_W-1:0] m,
                                               input logic [LEVEL_W-1:0] depth);
    logic [15:0] atten_full;
    logic [LEVEL_W-1:0] atten;
    atten_full = {8'd0, LEVEL_MAX - m} * {8'd0, depth} + {8'd0, LEVEL_MAX};
    atten = LEVEL_W'(atten_full >> 8);
    return (atten == LEVEL_MAX) ? 9'd0 : GAIN_UNITY - {1'b0, atten};
  endfunction

endpackage

// File: rtl/tremolo_lfo_shape.sv
// Combinational LFO waveform: maps an 8-bit phase to an 8-bit level.
module tremolo_lfo_shape
  import tremolo_pkg::*;
(
  input  logic [LEVEL_W-1:0] p,
  input  mode_e              mode_q,
  input  logic [LEVEL_W-1:0] Duty_Cycle,
  output logic [LEVEL_W-1:0] m
);

  logic [LEVEL_W-1:0] p_mirror;

  assign p_mirror = LEVEL_MAX - p;

  // Level lookup for the latched waveform; both square encodings share the default arm.
  always_comb begin
    // NOTE: m gets a default before the case so no path leaves it unassigned (no latch).
    m = '0;
    case (mode_q)
      // Rising half doubles p, falling half doubles (255-p); both fit in 8 bits.
      MODE_TRIANGLE: m = p[LEVEL_W-1] ? {p_mirror[LEVEL_W-2:0], 1'b0}
                                      : {p[LEVEL_W-2:0], 1'b0};
      MODE_RAMP:     m = p_mirror;
      default:       m = (p <= Duty_Cycle) ? LEVEL_MAX : '0;
    endcase
  end

endmodule

// File: rtl/tremolo_mc.sv
// Multi-channel tremolo: shared phase accumulator, per-channel phase spread,
// selectable LFO shape and a two-stage gain pipeline that also carries bypass.
module tremolo_mc
  import tremolo_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int CHANNELS    = 2,
  parameter int CTRL_W      = 8,
  parameter int PHASE_W     = 24,
  parameter int RATE_OFFSET = 64,
  parameter int RATE_SHIFT  = 4
) (
  input  logic                       Lrck,
  input  logic                       Reset_n,
  input  logic                       Enable,
  input  logic                       Sync,
  input  logic [1:0]                 Mode,
  input  logic [CTRL_W-1:0]          Rate,
  input  logic [CTRL_W-1:0]          Depth,
  input  logic [CTRL_W-1:0]          Duty_Cycle,
  input  logic [CTRL_W-1:0]          Spread,
  input  logic [CHANNELS*DATA_W-1:0] D_In,
  output logic [CHANNELS*DATA_W-1:0] D_Out,
  output logic [CTRL_W-1:0]          Lfo_Out
);

  // Phase accumulator and mode latch.
  logic [PHASE_W-1:0] ph;
  logic [PHASE_W-1:0] rate_ext;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W:0]   ph_sum;
  logic               wrap;
  mode_e              mode_q;

  // Control words reduced to the 8-bit level domain.
  logic [LEVEL_W-1:0] ph_top;
  logic [LEVEL_W-1:0] depth_lvl;
  logic [LEVEL_W-1:0] duty_lvl;
  logic [LEVEL_W-1:0] spread_lvl;

  // Pipeline: stage 1 holds sample and gain, stage 2 holds the product.
  logic [CHANNELS-1:0][8:0]        g_next;
  logic [CHANNELS-1:0][DATA_W-1:0] x_q;
  logic [CHANNELS-1:0][8:0]        g_q;
  logic [CHANNELS-1:0][DATA_W-1:0] y_next;
  logic [CHANNELS-1:0][DATA_W-1:0] y_q;

  assign rate_ext = PHASE_W'(Rate) + PHASE_W'(RATE_OFFSET);
  assign step     = rate_ext << RATE_SHIFT;
  assign ph_sum   = {1'b0, ph} + {1'b0, step};
  // Sync and a carry on the same edge count as a single wrap.
  assign wrap     = ph_sum[PHASE_W] | Sync;

  assign ph_top     = ph[PHASE_W-1 -: LEVEL_W];
  assign depth_lvl  = Depth[CTRL_W-1 -: LEVEL_W];
  assign duty_lvl   = Duty_Cycle[CTRL_W-1 -: LEVEL_W];
  assign spread_lvl = Spread[CTRL_W-1 -: LEVEL_W];

  // Advance the LFO phase; Sync or bypass parks it at zero, and Mode is only
  // taken on a wrap (or while bypassed) so a shape change never clicks mid-cycle.
  always_ff @(posedge Lrck or negedge Reset_n) begin
    if (!Reset_n) begin
      ph     <= '0;
      mode_q <= MODE_SQUARE;
    end else begin
      // NOTE: non-blocking updates, so stage 1 on this edge still sees the old ph and mode_q.
      if (Sync || !Enable) begin
        ph <= '0;
      end else begin
        ph <= ph_sum[PHASE_W-1:0];
      end
      if (!Enable || wrap) begin
        mode_q <= mode_e'(Mode);
      end
    end
  end

  // Per-channel phase offset, waveform, gain and scaling.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [LEVEL_W-1:0]       offset_c;
    logic [LEVEL_W-1:0]       p_c;
    logic [LEVEL_W-1:0]       m_c;
    logic signed [DATA_W+7:0] x_ext;
    logic signed [DATA_W+7:0] g_ext;
    logic signed [DATA_W+7:0] prod;

    assign offset_c = LEVEL_W'(c * spread_lvl);
    assign p_c      = ph_top + offset_c;

    tremolo_lfo_shape u_shape (
      .p          (p_c),
      .mode_q     (mode_q),
      .Duty_Cycle (duty_lvl),
      .m          (m_c)
    );

    assign g_next[c] = level_to_gain(m_c, depth_lvl);

    // Gain is at most 256, so the signed product fits in DATA_W+8 bits;
    // >>> 8 floors toward minus infinity and g=256 returns x exactly.
    assign x_ext     = {{8{x_q[c][DATA_W-1]}}, x_q[c]};
    assign g_ext     = {{(DATA_W-1){1'b0}}, g_q[c]};
    assign prod      = x_ext * g_ext;
    assign y_next[c] = DATA_W'(prod >>> 8);
  end

  // Stage 1: capture samples and gains; bypass forces unity so both modes share the delay.
  always_ff @(posedge Lrck or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: datapath registers are reset as well, so D_Out reads zero during and just after reset.
      x_q <= '0;
      g_q <= '0;
    end else begin
      x_q <= D_In;
      g_q <= Enable ? g_next : {CHANNELS{GAIN_UNITY}};
    end
  end

  // Stage 2: register the scaled samples.
  always_ff @(posedge Lrck or negedge Reset_n) begin
    if (!Reset_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_next;
    end
  end

  assign D_Out   = y_q;
  assign Lfo_Out = CTRL_W'(g_q[0][8:1]);

endmodule

// File: tb/tb_tremolo_mc.sv
// Directed bench for tremolo_mc with PHASE_W=16: Rate=0 gives a 64-sample
// period with the 8-bit phase stepping by 4 per sample.
module tb_tremolo_mc;

  logic        Lrck;
  logic        Reset_n;
  logic        Enable;
  logic        Sync;
  logic [1:0]  Mode;
  logic [7:0]  Rate;
  logic [7:0]  Depth;
  logic [7:0]  Duty_Cycle;
  logic [7:0]  Spread;
  logic [47:0] D_In;
  logic [47:0] D_Out;
  logic [7:0]  Lfo_Out;

  tremolo_mc #(
    .PHASE_W (16)
  ) dut (
    .Lrck       (Lrck),
    .Reset_n    (Reset_n),
    .Enable     (Enable),
    .Sync       (Sync),
    .Mode       (Mode),
    .Rate       (Rate),
    .Depth      (Depth),
    .Duty_Cycle (Duty_Cycle),
    .Spread     (Spread),
    .D_In       (D_In),
    .D_Out      (D_Out),
    .Lfo_Out    (Lfo_Out)
  );

  initial Lrck = 1'b0;
  always #5 Lrck = ~Lrck;

  int n_checks;
  int n_fail;
  string scen;

  // Bench-side phase and latched mode, plus a two-deep queue of expectations:
  // exp_s1 is the sample captured on the last edge, exp_out the one now on D_Out.
  logic [15:0] ph_b;
  logic [1:0]  mode_b;
  logic [23:0] off_val;
  logic [24:0] exp_s1 [2];
  logic [24:0] exp_out [2];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  // Hand-computed output for one channel given mode, phase and input sample.
  // Returns {valid, value}; triangle/ramp are tabulated at quarter points for Depth=255.
  function automatic logic [24:0] expect_ch(input logic [1:0] mode, input logic [7:0] p,
                                            input logic [23:0] x);
    logic [24:0] r;
    r = '0;
    if (mode == 2'b01 && x == 24'h7FFFFF) begin
      case (p)
        8'd0:    r = {1'b1, 24'h000000};
        8'd64:   r = {1'b1, 24'h407FFF};
        8'd128:  r = {1'b1, 24'h7F7FFF};
        8'd192:  r = {1'b1, 24'h3F7FFF};
        default: r = '0;
      endcase
    end else if (mode == 2'b01 && x == 24'h800000) begin
      case (p)
        8'd0:    r = {1'b1, 24'h000000};
        8'd64:   r = {1'b1, 24'hBF8000};
        8'd128:  r = {1'b1, 24'h808000};
        8'd192:  r = {1'b1, 24'hC08000};
        default: r = '0;
      endcase
    end else if (mode == 2'b10 && x == 24'h7FFFFF) begin
      case (p)
        8'd0:    r = {1'b1, 24'h7FFFFF};
        8'd64:   r = {1'b1, 24'h5FFFFF};
        8'd128:  r = {1'b1, 24'h3FFFFF};
        8'd192:  r = {1'b1, 24'h1FFFFF};
        default: r = '0;
      endcase
    end else if (mode == 2'b00 || mode == 2'b11) begin
      r = {1'b1, (p <= Duty_Cycle) ? x : off_val};
    end
    return r;
  endfunction

  task automatic bench_reset();
    ph_b   = '0;
    mode_b = 2'b00;
    for (int c = 0; c < 2; c++) begin
      exp_s1[c]  = {1'b1, 24'h000000};
      exp_out[c] = {1'b1, 24'h000000};
    end
  endtask

  // One Lrck edge: predict the captured sample, advance the bench phase,
  // then compare D_Out against the sample captured one edge earlier.
  task automatic tick();
    logic [24:0] cap [2];
    logic [16:0] sum;
    logic [15:0] step;
    logic        wrap;
    for (int c = 0; c < 2; c++) begin
      logic [23:0] x;
      logic [7:0]  pc;
      x = D_In[c*24 +: 24];
      pc = ph_b[15:8] + (c[7:0] * Spread);
      cap[c] = Enable ? expect_ch(mode_b, pc, x) : {1'b1, x};
    end
    step = ({8'd0, Rate} + 16'd64) << 4;
    @(posedge Lrck);
    sum  = {1'b0, ph_b} + {1'b0, step};
    wrap = sum[16] | Sync;
    if (!Enable || wrap) mode_b = Mode;
    ph_b = (Sync || !Enable) ? 16'd0 : sum[15:0];
    exp_out = exp_s1;
    exp_s1  = cap;
    #1;
    for (int c = 0; c < 2; c++) begin
      if (exp_out[c][24]) begin
        check($sformatf("%s D_Out ch%0d", scen, c), 48'(D_Out[c*24 +: 24]),
              48'(exp_out[c][23:0]));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next captured sample will use phase p == target.
  task automatic wait_p(input logic [7:0] target);
    for (int i = 0; i < 64; i++) begin
      if (ph_b[15:8] == target) break;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed time limit reached, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    Reset_n    = 1'b0;
    Enable     = 1'b0;
    Sync       = 1'b0;
    Mode       = 2'b00;
    Rate       = 8'd0;
    Depth      = 8'd255;
    Duty_Cycle = 8'd127;
    Spread     = 8'd0;
    D_In       = {24'h7FFFFF, 24'h7FFFFF};
    off_val    = 24'h000000;
    scen       = "reset";
    bench_reset();

    // Reset held across edges, then bypass after release.
    repeat (3) @(posedge Lrck);
    #1;
    check("reset D_Out", D_Out, 48'd0);
    check("reset Lfo_Out", 48'(Lfo_Out), 48'd0);
    Reset_n = 1'b1;
    scen = "bypass";
    run(6);

    // Square, full depth: 32 on / 32 off, then Duty 200 gives 51 on / 13 off.
    scen = "square50";
    Enable = 1'b1;
    run(128);
    scen = "square_duty200";
    Duty_Cycle = 8'd200;
    run(64);

    // Half depth: muted half becomes 407FFF.
    scen = "half_depth";
    Duty_Cycle = 8'd127;
    Depth = 8'd127;
    off_val = 24'h407FFF;
    run(64);

    // Triangle on negative full scale; takes effect at the next wrap.
    scen = "triangle_neg";
    Depth = 8'd255;
    off_val = 24'h000000;
    D_In = {24'h800000, 24'h800000};
    Mode = 2'b01;
    run(128);

    // Ramp-down on positive full scale.
    scen = "ramp";
    D_In = {24'h7FFFFF, 24'h7FFFFF};
    Mode = 2'b10;
    run(128);

    // Half-cycle spread: channel 1 is the complement of channel 0.
    scen = "spread";
    Mode = 2'b00;
    Spread = 8'd128;
    run(128);

    // Mode change mid-period holds square until the wrap.
    scen = "mode_change";
    Spread = 8'd0;
    wait_p(8'd40);
    Mode = 2'b01;
    run(96);

    // Sync in the muted half restarts at p=0 (on).
    scen = "sync";
    Mode = 2'b00;
    run(70);
    wait_p(8'd160);
    Sync = 1'b1;
    run(1);
    Sync = 1'b0;
    run(40);

    // Asynchronous reset mid-period, then restart.
    scen = "mid_reset";
    wait_p(8'd100);
    Reset_n = 1'b0;
    #1;
    check("mid_reset D_Out", D_Out, 48'd0);
    check("mid_reset Lfo_Out", 48'(Lfo_Out), 48'd0);
    bench_reset();
    repeat (2) @(posedge Lrck);
    #1;
    Reset_n = 1'b1;
    run(70);

    // Enable toggle with distinct channel data: bypass then restart at p=0.
    scen = "enable_toggle";
    Enable = 1'b0;
    D_In = {24'h123456, 24'h654321};
    run(5);
    Enable = 1'b1;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
